mem_requester: RTL

MEM_REQUESTER -- requirements
Module: mem_requester

---
 rtl/mem_bus_pkg.sv | 26 ++
 rtl/mem_req_timer.sv | 51 +++++
 rtl/mem_requester.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the memory requester and its timeout timer:
//   - state_e   : requester FSM states (IDLE / REQ / RESP)
//   - RW_READ / RW_WRITE : encoding of cmd_rw and the bus RW line
//   - MEM_ADDR_W / MEM_DATA_W : default address and data widths
// No ports (package).
// -----------------------------------------------------------------------------
package mem_bus_pkg;

  // Default bus widths used as parameter defaults by the requester.
  localparam int unsigned MEM_ADDR_W = 8;
  localparam int unsigned MEM_DATA_W = 32;

  // Direction encoding shared by the command port and the memory bus.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Requester FSM: one outstanding transaction at a time.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage : mem_bus_pkg

// File: rtl/mem_req_timer.sv
// -----------------------------------------------------------------------------
// mem_req_timer
// Counts REQ cycles spent waiting for the memory controller. Only built when
// MEM_REQUESTER_TIMEOUT_EN is defined.
// Ports:
//   clk     in  clock, rising edge
//   reset   in  asynchronous active-low reset (counter -> 0)
//   clear   in  restart the count (asserted on the edge that enters REQ)
//   enable  in  a REQ cycle without ready; counts up by one
//   expired out this enabled cycle is the TIMEOUT-th waiting cycle
// -----------------------------------------------------------------------------
module mem_req_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: clear wins, otherwise count waiting cycles, saturating at the top.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (enable && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // The count holds the number of waiting cycles already completed, so the
  // TIMEOUT-th waiting cycle is the one where it equals TIMEOUT-1; the edge
  // closing that cycle is where the count would reach TIMEOUT.
  assign expired = enable && (count_q == 8'(TIMEOUT - 1));

endmodule : mem_req_timer

// File: rtl/mem_requester.sv
// -----------------------------------------------------------------------------
// mem_requester
// Turns single commands (read/write) into a Valid/ready memory-bus transaction
// and returns one response per command. One transaction in flight at a time.
// Optional feature: define MEM_REQUESTER_TIMEOUT_EN to abort a REQ that waits
// TIMEOUT cycles for ready (response flagged with rsp_err=1).
// Ports:
//   clk, reset                 clock (rising edge) / async active-low reset
//   cmd_valid/cmd_ready        command handshake (cmd_ready high only in IDLE)
//   cmd_rw/cmd_addr/cmd_wdata  command direction, address, write data
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata/rsp_err          read data (0 for writes/timeouts) / timed out
//   Valid/RW/Addr              registered bus request, direction and address
//   Data_out/Data_oe           registered write data and its drive enable
//   Data_in/ready              bus read data / controller completion
// -----------------------------------------------------------------------------
module mem_requester
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = MEM_ADDR_W,
  parameter int unsigned DATA_W  = MEM_DATA_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              Valid,
  output logic              RW,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] Data_out,
  output logic              Data_oe,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              ready
);

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                data_oe_q, data_oe_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                timeout_s;

`ifdef MEM_REQUESTER_TIMEOUT_EN
  logic clear_s;
  logic enable_s;
  logic rsp_err_q, rsp_err_d;

  // Restart on the accepting edge; count every REQ cycle that sees no ready.
  assign clear_s  = (state_q == IDLE) && cmd_valid;
  assign enable_s = (state_q == REQ) && !ready;

  mem_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_s),
    .enable  (enable_s),
    .expired (timeout_s)
  );

  // Error flag: set only when REQ ends by timeout (ready has priority).
  always_comb begin
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: begin
        rsp_err_d = 1'b0;
      end
      REQ: begin
        if (ready) begin
          rsp_err_d = 1'b0;
        end else if (timeout_s) begin
          rsp_err_d = 1'b1;
        end else begin
          rsp_err_d = rsp_err_q;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_err_d = 1'b0;
        end else begin
          rsp_err_d = rsp_err_q;
        end
      end
      default: begin
        rsp_err_d = 1'b0;
      end
    endcase
  end

  // Error flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  // Without the timeout feature REQ waits for ready indefinitely.
  logic unused_timeout_s;
  assign unused_timeout_s = ^(32'(TIMEOUT));
  assign timeout_s        = 1'b0;
  assign rsp_err          = 1'b0;
`endif

  // FSM next state and next values of all registered bus/response outputs.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    data_out_d  = data_out_q;
    data_oe_d   = data_oe_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          // The bus registers double as the latched command; they are only
          // loaded here, so commands offered outside IDLE cannot disturb them.
          state_d = REQ;
          valid_d = 1'b1;
          rw_d    = cmd_rw;
          addr_d  = cmd_addr;
          if (cmd_rw == RW_WRITE) begin
            data_oe_d  = 1'b1;
            data_out_d = cmd_wdata;
          end else begin
            data_oe_d  = 1'b0;
            data_out_d = {DATA_W{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (ready) begin
          state_d     = RESP;
          valid_d     = 1'b0;
          data_oe_d   = 1'b0;
          data_out_d  = {DATA_W{1'b0}};
          rsp_valid_d = 1'b1;
          if (rw_q == RW_READ) begin
            rsp_rdata_d = Data_in;
          end else begin
            rsp_rdata_d = {DATA_W{1'b0}};
          end
        end else if (timeout_s) begin
          state_d     = RESP;
          valid_d     = 1'b0;
          data_oe_d   = 1'b0;
          data_out_d  = {DATA_W{1'b0}};
          rsp_valid_d = 1'b1;
          rsp_rdata_d = {DATA_W{1'b0}};
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        // Response is held untouched until consumed; ready is ignored here.
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        valid_d     = 1'b0;
        rw_d        = 1'b0;
        addr_d      = {ADDR_W{1'b0}};
        data_out_d  = {DATA_W{1'b0}};
        data_oe_d   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = {DATA_W{1'b0}};
      end
    endcase
  end

  // State and output registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      data_out_q  <= {DATA_W{1'b0}};
      data_oe_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign Valid     = valid_q;
  assign RW        = rw_q;
  assign Addr      = addr_q;
  assign Data_out  = data_out_q;
  assign Data_oe   = data_oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule : mem_requester
